truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Parametrised, self-checking exhaustive stimulus engine for combinational lab designs.
- Drives all 2^N_IN input combinations onto a DUT in ascending binary order. Holds each vector for a programmable dwell, samples the DUT output and compares it against a parameterised expected truth table.
- Reports error count, first failing vector and overall pass/fail.
- Instantiated in benches and on-board wrappers in place of hand-written delay-sequenced stimulus.

Parameters:
- N_IN, 4, number of DUT inputs (1..8); vector width.
- DWELL, 50, clock cycles each vector is held (>=2).
- EXPECT, 16'h0000, expected output truth table, width 2^N_IN; bit i is the expected y for vector i.
- LOOP, 0, 1 = restart sweep automatically after DONE; 0 = stop in DONE.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  begin sweep (pulse or level; sampled only in IDLE/DONE).
- hold  input  1  freeze dwell counter and vector while high.
- dut_y  input  1  DUT output under test.
- vec  output  N_IN  stimulus vector to DUT, MSB = first DUT input (a).
- busy  output  1  high during sweep.
- done  output  1  high in DONE state.
- pass  output  1  valid when done=1; 1 iff err_count==0.
- err_count  output  N_IN+1  mismatches in current/last sweep.
- first_err_vec  output  N_IN  vector of first mismatch; valid when err_seen=1.
- err_seen  output  1  at least one mismatch recorded this sweep.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. All state updates on the rising edge of clk.
- Reset: state=IDLE; vec=0, busy=0, done=0, pass=0, err_count=0, first_err_vec=0, err_seen=0, dwell counter=0. rst has priority over every other input, including mid-sweep; the sweep is abandoned with no partial result retained.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 -> RUN. On this transition: vec=0, dwell_cnt=0, err_count=0, err_seen=0, first_err_vec=0, busy=1.
- RUN:
  - dwell_cnt counts 0..DWELL-1 per vector.
  - The sample point is the cycle where dwell_cnt==DWELL-1 and hold=0. At that cycle, dut_y is compared with EXPECT[vec].
  - On mismatch, err_count increments. If err_seen=0, first_err_vec=vec and err_seen=1.
  - If vec < 2^N_IN-1, at the sample point vec increments and dwell_cnt=0.
  - If vec == 2^N_IN-1, at the sample point: state -> DONE, busy=0, done=1, pass=(final err_count==0), including the last comparison. vec stays at all-ones.
- hold=1 in RUN: dwell_cnt and vec frozen; no comparison occurs. Sampling resumes when hold drops.
- DONE: outputs held. If LOOP=1, the next cycle behaves as start=1 from IDLE. If LOOP=0, start=1 restarts the same way; otherwise DONE persists.
- start in RUN is ignored.
- Latency: start accepted at edge k -> vec=0 visible after edge k. Each vector is visible for exactly DWELL cycles (no hold). done=1 after edge k+2^N_IN*DWELL.
- err_count cannot overflow; its maximum is 2^N_IN and it is N_IN+1 bits wide.
- EXPECT is indexed with vec directly (no reordering).

Decomposition:
- Shared package tts_pkg: state enum {IDLE, RUN, DONE}, localparam NVEC = 2**N_IN, and a function to compute dwell counter width (clog2(DWELL)).
- One natural sub-module: tts_dwell_counter, a modulo-DWELL counter with enable (=!hold) and terminal-count output, reused for the sample strobe.
- Comparator and error bookkeeping stay in the top module.

Test Plan:
- N_IN=4, DWELL=4, EXPECT=16'hF888, dut_y driven by the model y=(a&b)|(c&d) from vec. Pulse start at edge k -> done=1 at k+64, pass=1, err_count=0, err_seen=0.
- Same configuration, DUT stuck at 0 -> done=1, err_count=7, first_err_vec=4'h3, pass=0.
- Same configuration, DUT faulted only at vec=4'hB (inverted output) -> err_count=1, first_err_vec=4'hB, err_seen=1.
- Assert hold for 10 cycles while vec=4'h5 -> vec remains 5 for 14 cycles, total sweep 74 cycles, results identical to the first case.
- Assert rst at vec=4'h9 mid-sweep -> next cycle: IDLE, vec=0, busy=0, err_count=0. A new start gives a full 64-cycle sweep.
- LOOP=1 -> after done, vec returns to 0 one cycle later with busy=1 and err_count cleared. start pulsed during RUN has no effect on timing.

Source files
------------

// File: rtl/tts_pkg.sv
// Shared types and helpers for the truth-table sweeper.
package tts_pkg;

    // Sweep controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tts_state_e;

    // Number of input vectors for an N-input DUT
    function automatic int nvec(input int n_in);
        return 1 << n_in;
    endfunction

    // Width of a counter that spans 0..dwell-1 (at least one bit)
    function automatic int cnt_width(input int dwell);
        if (dwell <= 2) begin
            return 1;
        end else begin
            return $clog2(dwell);
        end
    endfunction

endpackage

// File: rtl/tts_dwell_counter.sv
// Modulo-DWELL counter with enable; tc marks the last cycle of a dwell period
// and doubles as the sample strobe for the sweeper.
module tts_dwell_counter
    import tts_pkg::*;
#(
    parameter int DWELL = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int             W    = cnt_width(DWELL);
    localparam logic [W-1:0]   LAST = W'(DWELL - 1);

    logic [W-1:0] cnt_r;

    // Count 0..DWELL-1 while enabled, wrapping at the terminal count
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en) begin
            if (cnt_r == LAST) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + W'(1'b1);
            end
        end
    end

    assign tc = (cnt_r == LAST);

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus engine: walks every input vector in ascending order,
// holds each for DWELL cycles, compares the DUT output with EXPECT at the end
// of the dwell and keeps an error count plus the first failing vector.
module truth_table_sweeper
    import tts_pkg::*;
#(
    parameter int                    N_IN   = 4,
    parameter int                    DWELL  = 50,
    parameter logic [(2**N_IN)-1:0]  EXPECT = 16'h0000,
    parameter int                    LOOP   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              hold,
    input  logic              dut_y,
    output logic [N_IN-1:0]   vec,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic [N_IN-1:0]   first_err_vec,
    output logic              err_seen
);

    localparam int              NVEC     = nvec(N_IN);
    localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NVEC - 1);

    tts_state_e      state_r;
    tts_state_e      state_next_s;
    logic            start_go_s;
    logic            tc_s;
    logic            sample_s;
    logic            mismatch_s;
    logic            last_s;
    logic [N_IN:0]   err_next_s;

    logic [N_IN-1:0] vec_r;
    logic            busy_r;
    logic            done_r;
    logic            pass_r;
    logic [N_IN:0]   err_count_r;
    logic [N_IN-1:0] first_err_vec_r;
    logic            err_seen_r;

    // Sampling is suppressed while hold is high, so the dwell simply stretches
    assign sample_s   = (state_r == RUN) && tc_s && !hold;
    assign mismatch_s = dut_y ^ EXPECT[vec_r];
    assign last_s     = (vec_r == LAST_VEC);
    assign err_next_s = err_count_r + (N_IN+1)'(mismatch_s);

    tts_dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk (clk),
        .rst (rst),
        .clr (start_go_s),
        .en  ((state_r == RUN) && !hold),
        .tc  (tc_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; start_go_s flags the cycle a sweep (re)starts
    always_comb begin
        state_next_s = state_r;
        start_go_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = RUN;
                    start_go_s   = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (sample_s && last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                if ((LOOP != 0) || start) begin
                    state_next_s = RUN;
                    start_go_s   = 1'b1;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Vector stepping, comparison bookkeeping and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_r           <= '0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            pass_r          <= 1'b0;
            err_count_r     <= '0;
            first_err_vec_r <= '0;
            err_seen_r      <= 1'b0;
        end else if (start_go_s) begin
            vec_r           <= '0;
            busy_r          <= 1'b1;
            done_r          <= 1'b0;
            pass_r          <= 1'b0;
            err_count_r     <= '0;
            first_err_vec_r <= '0;
            err_seen_r      <= 1'b0;
        end else if (sample_s) begin
            err_count_r <= err_next_s;
            if (mismatch_s && !err_seen_r) begin
                first_err_vec_r <= vec_r;
                err_seen_r      <= 1'b1;
            end
            if (last_s) begin
                busy_r <= 1'b0;
                done_r <= 1'b1;
                pass_r <= (err_next_s == '0);
            end else begin
                vec_r <= vec_r + N_IN'(1'b1);
            end
        end
    end

    assign vec           = vec_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign pass          = pass_r;
    assign err_count     = err_count_r;
    assign first_err_vec = first_err_vec_r;
    assign err_seen      = err_seen_r;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: a lab DUT y=(a&b)|(c&d) with injectable faults
// is swept by a LOOP=0 instance (table + random sweeps, hold, reset) and a
// LOOP=1 instance (auto-restart behaviour).
module tb_truth_table_sweeper;

    localparam int          N  = 4;
    localparam int          DW = 4;
    localparam logic [15:0] TT = 16'hF888;

    typedef struct {
        logic [15:0] mask;
        int          hold_vec;
        int          hold_len;
        int          exp_err;
        int          exp_first;
        bit          exp_pass;
        int          exp_cycles;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, start0, hold0, start1, hold1;
    logic [15:0] mask0, mask1;
    logic [3:0]  vec0, vec1, first0, first1;
    logic [4:0]  err0, err1;
    logic        busy0, done0, pass0, seen0;
    logic        busy1, done1, pass1, seen1;
    logic        dut_y0, dut_y1;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic lab_y(input logic [3:0] v);
        return (v[3] & v[2]) | (v[1] & v[0]);
    endfunction

    assign dut_y0 = lab_y(vec0) ^ mask0[vec0];
    assign dut_y1 = lab_y(vec1) ^ mask1[vec1];

    truth_table_sweeper #(.N_IN(N), .DWELL(DW), .EXPECT(TT), .LOOP(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .hold(hold0), .dut_y(dut_y0),
        .vec(vec0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .first_err_vec(first0), .err_seen(seen0));

    truth_table_sweeper #(.N_IN(N), .DWELL(DW), .EXPECT(TT), .LOOP(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .hold(hold1), .dut_y(dut_y1),
        .vec(vec1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_err_vec(first1), .err_seen(seen1));

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference: mismatches of the (possibly faulted) lab DUT against the table
    task automatic model_sweep(input logic [15:0] m, output int err, output int first);
        logic [15:0] tt;
        logic [3:0]  v;
        tt = TT; err = 0; first = 0;
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            if ((lab_y(v) ^ m[i]) != tt[i]) begin
                if (err == 0) first = i;
                err++;
            end
        end
    endtask

    // Start a sweep on dut0 and run until done (bounded); reports cycles from
    // the start edge to done and whether each vector was held the right time.
    task automatic run_sweep(input logic [15:0] m, input int hv, input int hl,
                             input bit rs, output int cyc, output bit occ_ok);
        int occ[16];
        int left;
        bit hdone;
        for (int i = 0; i < 16; i++) occ[i] = 0;
        left = 0; hdone = 1'b0; cyc = 0;
        @(negedge clk); mask0 = m; start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        while (!done0 && cyc < 300) begin
            occ[vec0]++;
            if (int'(vec0) == hv && !hdone && hl > 0) begin
                hold0 = 1'b1; left = hl; hdone = 1'b1;
            end
            start0 = rs ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk); cyc++;
            if (left > 0) begin
                left--;
                if (left == 0) hold0 = 1'b0;
            end
        end
        start0 = 1'b0; hold0 = 1'b0;
        occ_ok = 1'b1;
        for (int i = 0; i < 16; i++)
            if (occ[i] != DW + ((i == hv) ? hl : 0)) occ_ok = 1'b0;
    endtask

    task automatic check_result(input string tag, input vec_t t, input int cyc, input bit occ_ok);
        check({tag, "_cycles"}, cyc, t.exp_cycles);
        check({tag, "_dwell"}, int'(occ_ok), 1);
        check({tag, "_done"}, int'(done0), 1);
        check({tag, "_busy"}, int'(busy0), 0);
        check({tag, "_err_count"}, int'(err0), t.exp_err);
        check({tag, "_err_seen"}, int'(seen0), (t.exp_err != 0) ? 1 : 0);
        check({tag, "_first_err"}, int'(first0), t.exp_first);
        check({tag, "_pass"}, int'(pass0), int'(t.exp_pass));
        check({tag, "_vec_last"}, int'(vec0), 15);
    endtask

    initial begin
        vec_t tbl[6];
        vec_t r;
        int   cyc, c, e, f;
        bit   ok;

        tbl[0] = '{16'h0000, -1,  0,  0, 0,  1'b1, 64};   // good DUT
        tbl[1] = '{16'hF888, -1,  0,  7, 3,  1'b0, 64};   // stuck at 0
        tbl[2] = '{16'h0800, -1,  0,  1, 11, 1'b0, 64};   // wrong only at B
        tbl[3] = '{16'h0000,  5, 10,  0, 0,  1'b1, 74};   // hold 10 at vec 5
        tbl[4] = '{16'h8001, -1,  0,  2, 0,  1'b0, 64};   // first and last vector
        tbl[5] = '{16'hFFFF, -1,  0, 16, 0,  1'b0, 64};   // every vector wrong

        rst = 1'b1; start0 = 1'b0; hold0 = 1'b0; start1 = 1'b0; hold1 = 1'b0;
        mask0 = 16'h0000; mask1 = 16'h0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_vec", int'(vec0), 0);
        check("rst_busy", int'(busy0), 0);
        check("rst_done", int'(done0), 0);
        check("rst_pass", int'(pass0), 0);
        check("rst_err_count", int'(err0), 0);
        check("rst_first_err", int'(first0), 0);
        check("rst_err_seen", int'(seen0), 0);

        for (int i = 0; i < 6; i++) begin
            run_sweep(tbl[i].mask, tbl[i].hold_vec, tbl[i].hold_len, 1'b0, cyc, ok);
            check_result($sformatf("tbl%0d", i), tbl[i], cyc, ok);
        end

        // DONE persists without start when LOOP=0
        repeat (5) @(negedge clk);
        check("done_persist", int'(done0), 1);
        check("done_persist_err", int'(err0), 16);

        // Reset in the middle of a faulty sweep
        @(negedge clk); mask0 = 16'hF888; start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        c = 0;
        while (vec0 != 4'h9 && c < 100) begin @(negedge clk); c++; end
        check("midrst_reach_vec9", int'(vec0), 9);
        check("midrst_err_before", int'(err0), 2);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("midrst_vec", int'(vec0), 0);
        check("midrst_busy", int'(busy0), 0);
        check("midrst_err", int'(err0), 0);
        check("midrst_seen", int'(seen0), 0);
        @(negedge clk);
        check("midrst_idle_vec", int'(vec0), 0);
        check("midrst_idle_busy", int'(busy0), 0);
        run_sweep(tbl[0].mask, -1, 0, 1'b0, cyc, ok);
        check_result("after_rst", tbl[0], cyc, ok);

        // Random fault masks, holds and ignored start pulses vs. the model
        for (int k = 0; k < 8; k++) begin
            r.mask     = 16'($urandom);
            r.hold_vec = $urandom_range(0, 15);
            r.hold_len = $urandom_range(0, 6);
            model_sweep(r.mask, e, f);
            r.exp_err = e; r.exp_first = f; r.exp_pass = (e == 0);
            r.exp_cycles = 64 + r.hold_len;
            run_sweep(r.mask, r.hold_vec, r.hold_len, 1'b1, cyc, ok);
            check_result($sformatf("rnd%0d", k), r, cyc, ok);
        end

        // LOOP=1: auto-restart one cycle after done, with results cleared
        @(negedge clk); mask1 = 16'hF888; start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        cyc = 0;
        while (!done1 && cyc < 300) begin
            start1 = 1'($urandom_range(0, 1));
            @(negedge clk); cyc++;
        end
        start1 = 1'b0;
        check("loop_cycles1", cyc, 64);
        check("loop_err1", int'(err1), 7);
        check("loop_pass1", int'(pass1), 0);
        @(negedge clk); mask1 = 16'h0000;
        check("loop_restart_vec", int'(vec1), 0);
        check("loop_restart_busy", int'(busy1), 1);
        check("loop_restart_done", int'(done1), 0);
        check("loop_restart_err", int'(err1), 0);
        cyc = 0;
        while (!done1 && cyc < 300) begin
            start1 = 1'($urandom_range(0, 1));
            @(negedge clk); cyc++;
        end
        start1 = 1'b0;
        check("loop_cycles2", cyc, 64);
        check("loop_err2", int'(err1), 0);
        check("loop_pass2", int'(pass1), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
